// File: rtl/instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : instr_fetch_unit                                                |
// | Brief    : MIPS fetch stage. It holds the PC, fetches words over req/ready |
// |            and applies branch/jump redirects when the held instruction     |
// |            retires. FETCH_PERF_EN adds retire and stall counters.          |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module instr_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        branch_taken,
  input  logic [31:0] branch_offset,
  input  logic        jump,
  input  logic [25:0] jump_index,
  output logic [31:0] instr,
  output logic [5:0]  opcode,
  output logic [5:0]  funct,
  output logic [31:0] pc_out,
  output logic [31:0] pc_plus4,
  output logic        instr_valid,
  output logic [31:0] perf_retired,
  output logic [31:0] perf_stall
);

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state_q;
  logic [31:0] pc_q;
  logic [31:0] instr_q;
  logic        valid_q;
  logic [31:0] next_pc_d;
  logic        w_retire;

  assign w_retire = (state_q == HOLD) && !stall;

  always_comb begin
    next_pc_d = pc_plus4;
    if (jump) begin
      next_pc_d = {pc_plus4[31:28], jump_index, 2'b00};
    end else if (branch_taken) begin
      next_pc_d = pc_plus4 + (branch_offset << 2);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= FETCH;
      pc_q    <= RESET_PC;
      instr_q <= 32'h0;
      valid_q <= 1'b0;
    end else begin
      case (state_q)
        FETCH: begin
          if (imem_ready) begin
            instr_q <= imem_rdata;
            valid_q <= 1'b1;
            state_q <= HOLD;
          end
        end
        HOLD: begin
          if (w_retire) begin
            pc_q    <= next_pc_d;
            valid_q <= 1'b0;
            state_q <= FETCH;
          end
        end
        default: state_q <= FETCH;
      endcase
    end
  end

  // The request is masked during reset so an abandoned fetch never reaches memory.
  assign imem_req    = (state_q == FETCH) && !reset;
  assign imem_addr   = pc_q;
  assign instr       = instr_q;
  assign opcode      = instr_q[31:26];
  assign funct       = instr_q[5:0];
  assign pc_out      = pc_q;
  assign pc_plus4    = pc_q + 32'd4;
  assign instr_valid = valid_q;

`ifdef FETCH_PERF_EN
  logic [31:0] retired_q;
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      retired_q   <= 32'h0;
      stall_cnt_q <= 32'h0;
    end else begin
      if (w_retire) begin
        retired_q <= retired_q + 32'd1;
      end
      if ((state_q == HOLD) && stall) begin
        stall_cnt_q <= stall_cnt_q + 32'd1;
      end
    end
  end

  assign perf_retired = retired_q;
  assign perf_stall   = stall_cnt_q;
`else
  assign perf_retired = 32'h0;
  assign perf_stall   = 32'h0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// +----------------------------------------------------------------------------+
// | Module   : tb_instr_fetch_unit                                             |
// | Brief    : Directed self-checking bench for instr_fetch_unit.              |
// | Revision : 1.0  initial release                                            |
// +----------------------------------------------------------------------------+
module tb_instr_fetch_unit;

  logic        clk;
  logic        reset;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall;
  logic        branch_taken;
  logic [31:0] branch_offset;
  logic        jump;
  logic [25:0] jump_index;
  logic [31:0] instr;
  logic [5:0]  opcode;
  logic [5:0]  funct;
  logic [31:0] pc_out;
  logic [31:0] pc_plus4;
  logic        instr_valid;
  logic [31:0] perf_retired;
  logic [31:0] perf_stall;

  int n_cmp;
  int n_bad;
  int exp_ret;
  int exp_stl;

  localparam logic [31:0] ADDI = 32'h2008_0005;

  instr_fetch_unit #(.RESET_PC(32'h0000_0000)) u_dut (
    .clk           (clk),
    .reset         (reset),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ready    (imem_ready),
    .imem_rdata    (imem_rdata),
    .stall         (stall),
    .branch_taken  (branch_taken),
    .branch_offset (branch_offset),
    .jump          (jump),
    .jump_index    (jump_index),
    .instr         (instr),
    .opcode        (opcode),
    .funct         (funct),
    .pc_out        (pc_out),
    .pc_plus4      (pc_plus4),
    .instr_valid   (instr_valid),
    .perf_retired  (perf_retired),
    .perf_stall    (perf_stall)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_perf(input string tag);
`ifdef FETCH_PERF_EN
    check_eq({tag, "_ret"}, perf_retired, exp_ret);
    check_eq({tag, "_stl"}, perf_stall, exp_stl);
`else
    check_eq({tag, "_ret"}, perf_retired, 32'h0);
    check_eq({tag, "_stl"}, perf_stall, 32'h0);
`endif
  endtask

  // Called at a negedge in FETCH; returns at the negedge in HOLD.
  task automatic do_fetch(input logic [31:0] data);
    imem_ready = 1'b1;
    imem_rdata = data;
    @(posedge clk);
    @(negedge clk);
    imem_ready = 1'b0;
    imem_rdata = 32'hDEAD_BEEF;
  endtask

  // Called at a negedge in HOLD; returns at the negedge in the next FETCH.
  task automatic do_retire(input logic j, input logic [25:0] idx,
                           input logic b, input logic [31:0] off);
    stall         = 1'b0;
    jump          = j;
    jump_index    = idx;
    branch_taken  = b;
    branch_offset = off;
    @(posedge clk);
    @(negedge clk);
    exp_ret++;
    jump          = 1'b1;
    jump_index    = 26'h3FF_FFFF;
    branch_taken  = 1'b1;
    branch_offset = 32'h1234_5678;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    n_cmp = 0; n_bad = 0; exp_ret = 0; exp_stl = 0;
    reset = 1'b1; imem_ready = 1'b0; imem_rdata = 32'h0; stall = 1'b0;
    branch_taken = 1'b0; branch_offset = 32'h0; jump = 1'b0; jump_index = 26'h0;
    @(negedge clk); @(negedge clk);
    check_eq("rst_req",   imem_req,    0);
    check_eq("rst_valid", instr_valid, 0);
    check_eq("rst_instr", instr,       32'h0);
    check_eq("rst_pc",    pc_out,      32'h0);
    check_perf("rst");
    reset = 1'b0;
    @(negedge clk);

    // Sequential fetch, zero wait states
    check_eq("seq_req0",  imem_req,  1);
    check_eq("seq_addr0", imem_addr, 32'h0);
    do_fetch(ADDI);
    check_eq("seq_valid0", instr_valid, 1);
    check_eq("seq_opc0",   opcode,      6'h08);
    check_eq("seq_fn0",    funct,       6'h05);
    check_eq("seq_p4_0",   pc_plus4,    32'h4);
    check_eq("seq_hreq0",  imem_req,    0);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0);
    check_eq("seq_addr4",  imem_addr,   32'h4);
    check_eq("seq_inv4",   instr_valid, 0);

    // Wait states at address 4
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check_eq("ws_req",   imem_req,    1);
      check_eq("ws_addr",  imem_addr,   32'h4);
      check_eq("ws_valid", instr_valid, 0);
    end
    do_fetch(32'h0000_0020);
    check_eq("ws_valid_after", instr_valid, 1);
    check_eq("ws_pc",          pc_out,      32'h4);
    check_eq("ws_funct",       funct,       6'h20);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0);
    check_eq("seq_addr8", imem_addr, 32'h8);

    // Backward branch from 8: 12 - 8 = 4
    do_fetch(ADDI);
    do_retire(1'b0, 26'h0, 1'b1, 32'hFFFF_FFFE);
    check_eq("br_taken_addr", imem_addr, 32'h4);
    do_fetch(ADDI);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0);
    do_fetch(ADDI);
    check_eq("br_pc8", pc_out, 32'h8);
    do_retire(1'b0, 26'h0, 1'b0, 32'hFFFF_FFFE);
    check_eq("br_not_addr", imem_addr, 32'hC);

    // Branch far to 0x1000_0010, then jump beats branch there
    do_fetch(ADDI);
    do_retire(1'b0, 26'h0, 1'b1, 32'h0400_0000);
    check_eq("br_far_addr", imem_addr, 32'h1000_0010);
    do_fetch(32'h0800_0040);
    check_eq("jmp_opc", opcode, 6'h02);
    do_retire(1'b1, 26'h40, 1'b1, 32'h0000_0010);
    check_eq("jmp_addr", imem_addr, 32'h1000_0100);

    // Stall in HOLD: outputs frozen, no fetch
    do_fetch(ADDI);
    stall = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      exp_stl++;
      check_eq("stl_req",   imem_req,    0);
      check_eq("stl_valid", instr_valid, 1);
      check_eq("stl_pc",    pc_out,      32'h1000_0100);
      check_eq("stl_instr", instr,       ADDI);
    end
    check_perf("stl");
    do_retire(1'b0, 26'h0, 1'b0, 32'h0);
    check_eq("stl_rel_addr", imem_addr, 32'h1000_0104);
    check_perf("rel");

    // Branch to top of memory, then sequential wrap to 0
    do_fetch(ADDI);
    do_retire(1'b0, 26'h0, 1'b1, 32'h3BFF_FFBD);
    check_eq("top_addr", imem_addr, 32'hFFFF_FFFC);
    do_fetch(ADDI);
    check_eq("top_p4", pc_plus4, 32'h0);
    do_retire(1'b0, 26'h0, 1'b0, 32'h0);
    check_eq("wrap_addr", imem_addr, 32'h0);

    // Reach 0x20, then reset in a wait state
    do_fetch(ADDI);
    do_retire(1'b0, 26'h0, 1'b1, 32'h0000_0007);
    check_eq("mid_addr", imem_addr, 32'h20);
    @(negedge clk);
    imem_rdata = ADDI;
    reset = 1'b1;
    exp_ret = 0; exp_stl = 0;
    #1;
    check_eq("mid_rst_req",   imem_req,    0);
    check_eq("mid_rst_addr",  imem_addr,   32'h0);
    check_eq("mid_rst_valid", instr_valid, 0);
    check_eq("mid_rst_instr", instr,       32'h0);
    check_perf("mid_rst");
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check_eq("post_req",   imem_req,    1);
    check_eq("post_addr",  imem_addr,   32'h0);
    check_eq("post_valid", instr_valid, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
